beep_scheduler: RTL and testbench

Shares the single buzzer between up to four beep requesters: key-press clicks, alarms and status events. Each requester asks for a burst of N beeps. The scheduler picks one requester by fixed priority, acknowledges it, and plays the burst with fixed on/off timing. It sits between the debounced key/event logic and the `beep` pin, replacing direct per-source beep control.

---
 rtl/beep_scheduler.sv | 169 ++++++++++++++++
 tb/tb_beep_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/beep_scheduler.sv
// Fixed-priority buzzer scheduler: grants one of four requesters and plays an N-beep burst.
// Optional macro BEEP_TONE_EN: drive a square-wave tone during ON (passive buzzer).
module beep_scheduler #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int ON_MS    = 100,
  parameter int OFF_MS   = 100,
  parameter int TONE_HZ  = 2000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [11:0] req_cnt,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        beep
);

  localparam int ON_CYC   = CLK_FREQ / 1000 * ON_MS;
  localparam int OFF_CYC  = CLK_FREQ / 1000 * OFF_MS;
  localparam int HALF_CYC = CLK_FREQ / (2 * TONE_HZ);
  localparam int MAX_CYC  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);

  generate
    if (ON_CYC < 1 || OFF_CYC < 1 || HALF_CYC < 1) begin : g_bad_cfg
      $error("beep_scheduler: derived cycle constants must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2, ST_GAP = 2'd3} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_remain;
  logic [2:0]       w_remain_nxt;
  logic             w_grant;
  logic [1:0]       w_sel;

  function automatic logic [1:0] f_pick(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // A zero count still plays one beep.
  function automatic logic [2:0] f_count(input logic [11:0] c, input logic [1:0] s);
    logic [2:0] v;
    case (s)
      2'd0:    v = c[2:0];
      2'd1:    v = c[5:3];
      2'd2:    v = c[8:6];
      default: v = c[11:9];
    endcase
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

  assign w_sel = f_pick(req);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_remain <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_remain_nxt = r_remain;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_grant      = 1'b1;
          w_state_nxt  = ST_ON;
          w_cnt_nxt    = '0;
          w_remain_nxt = f_count(req_cnt, w_sel);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == ON_LAST) begin
          w_cnt_nxt = '0;
          if (r_remain > 3'd1) begin
            w_remain_nxt = r_remain - 3'd1;
            w_state_nxt  = ST_OFF;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_OFF, ST_GAP: begin
        if (r_cnt == OFF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == ST_OFF) ? ST_ON : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ack      <= 4'b0000;
      busy     <= 1'b0;
      grant_id <= 2'd0;
    end else begin
      ack      <= w_grant ? (4'b0001 << w_sel) : 4'b0000;
      busy     <= (w_state_nxt != ST_IDLE);
      grant_id <= w_grant ? w_sel : grant_id;
    end
  end

`ifdef BEEP_TONE_EN
  localparam int TONE_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(HALF_CYC - 1);
  logic [TONE_W-1:0] r_tone_cnt;

  // Square wave restarts high on every ON entry.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_tone_cnt <= '0;
      beep       <= 1'b0;
    end else if (w_state_nxt == ST_ON) begin
      if (r_state != ST_ON) begin
        r_tone_cnt <= '0;
        beep       <= 1'b1;
      end else if (r_tone_cnt == HALF_LAST) begin
        r_tone_cnt <= '0;
        beep       <= ~beep;
      end else begin
        r_tone_cnt <= r_tone_cnt + TONE_W'(1);
      end
    end else begin
      r_tone_cnt <= '0;
      beep       <= 1'b0;
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      beep <= 1'b0;
    end else begin
      beep <= (w_state_nxt == ST_ON);
    end
  end
`endif

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: stimulus queues expected bursts, a monitor checks them.
module tb_beep_scheduler;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int HALF = 2;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req;
  logic [11:0] req_cnt;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        beep;

  beep_scheduler #(.CLK_FREQ(1000), .ON_MS(4), .OFF_MS(3), .TONE_HZ(250)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_cnt(req_cnt),
    .ack(ack), .busy(busy), .grant_id(grant_id), .beep(beep)
  );

  typedef struct { int id; int n; bit b2b; } burst_t;
  burst_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  // Reference burst shape: n periods of ON active cycles followed by OFF silent cycles.
  function automatic bit exp_beep(input int idx);
    int p;
    p = idx % (ON + OFF);
    if (p >= ON) return 1'b0;
`ifdef BEEP_TONE_EN
    return ((p % (2 * HALF)) < HALF);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor
  initial begin
    int cyc = 0, idx = 0, blen = 0, fall_cyc = -100;
    bit in_burst = 0, prev_busy = 0;
    burst_t rec;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst) begin
        in_burst = 0;
        prev_busy = 0;
      end else begin
        if (ack != 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_ack", int'(ack), 0);
          end else begin
            rec = exp_q.pop_front();
            chk(ack == (4'b0001 << rec.id), "ack_onehot", int'(ack), int'(4'b0001 << rec.id));
            chk(int'(grant_id) == rec.id, "grant_id", int'(grant_id), rec.id);
            chk(!prev_busy, "ack_while_busy", int'(prev_busy), 0);
            if (rec.b2b) chk(cyc - fall_cyc == 1, "b2b_gap", cyc - fall_cyc, 1);
            in_burst = 1;
            idx = 0;
            blen = rec.n * (ON + OFF);
          end
        end
        if (in_burst) begin
          if (busy) begin
            chk(beep == exp_beep(idx), "beep_pattern", int'(beep), int'(exp_beep(idx)));
            idx++;
          end else begin
            chk(idx == blen, "busy_len", idx, blen);
            chk(!beep, "beep_after_burst", int'(beep), 0);
            in_burst = 0;
            fall_cyc = cyc;
          end
        end else begin
          chk(!busy && !beep, "idle_outputs", int'({busy, beep}), 0);
        end
        prev_busy = busy;
      end
    end
  end

  // One cycle of the requester: drop any request the cycle after its ack, then scramble its count.
  task automatic tick();
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      if (ack[k]) begin
        req[k] = 1'b0;
        req_cnt[3*k +: 3] = 3'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req != 4'b0000 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk(1'b0, "idle_timeout", n, budget);
  endtask

  task automatic do_round(input logic [3:0] mask, input logic [11:0] cnts);
    burst_t r;
    bit first = 1;
    wait_idle(1000);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        req_cnt[3*k +: 3] = cnts[3*k +: 3];
        r.id  = k;
        r.n   = (cnts[3*k +: 3] == 3'd0) ? 1 : int'(cnts[3*k +: 3]);
        r.b2b = !first;
        exp_q.push_back(r);
        first = 0;
      end
    end
    req = req | mask;
    wait_idle(2000);
    repeat (3) tick();
  endtask

  initial begin
    burst_t r;
    int beeps;
    sys_rst = 1'b0;
    req     = 4'b0000;
    req_cnt = 12'h000;
    repeat (3) @(negedge sys_clk);
    chk(!beep && !busy && ack == 4'b0000 && grant_id == 2'd0, "reset_state",
        int'({beep, busy, ack, grant_id}), 0);
    sys_rst = 1'b1;
    repeat (2) tick();

    // Single request, count 2
    do_round(4'b0100, 12'b000_010_000_000);
    // Simultaneous requests 1 and 3, count 1 each
    do_round(4'b1010, 12'b001_000_001_000);
    // Zero count maps to one beep
    do_round(4'b0001, 12'b000_000_000_000);

    // Withdrawn request during a busy burst
    wait_idle(1000);
    tick();
    req_cnt[5:3] = 3'd2;
    r.id = 1; r.n = 2; r.b2b = 0;
    exp_q.push_back(r);
    req[1] = 1'b1;
    repeat (5) tick();
    req[3] = 1'b1;
    repeat (6) tick();
    chk(busy, "busy_during_withdraw", int'(busy), 1);
    req[3] = 1'b0;
    wait_idle(1000);
    repeat (20) tick();
    chk(!busy && !beep, "withdraw_idle", int'({busy, beep}), 0);

    // Reset mid-burst
    tick();
    req_cnt[8:6] = 3'd3;
    r.id = 2; r.n = 3; r.b2b = 0;
    exp_q.push_back(r);
    req[2] = 1'b1;
    begin
      int n = 0;
      while (!beep && n < 50) begin tick(); n++; end
      chk(beep, "beep_before_reset", int'(beep), 1);
    end
    tick();
    #2 sys_rst = 1'b0;
    #1;
    chk(!beep, "rst_beep", int'(beep), 0);
    chk(!busy, "rst_busy", int'(busy), 0);
    chk(ack == 4'b0000, "rst_ack", int'(ack), 0);
    chk(grant_id == 2'd0, "rst_grant_id", int'(grant_id), 0);
    req = 4'b0000;
    repeat (3) tick();
    sys_rst = 1'b1;
    beeps = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (beep || busy) beeps++;
    end
    chk(beeps == 0, "post_reset_quiet", beeps, 0);

    // Randomized rounds
    for (int i = 0; i < 20; i++) begin
      do_round(4'($urandom_range(1, 15)), 12'($urandom));
    end

    wait_idle(1000);
    repeat (5) tick();
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
